param_counter_bank: RTL and testbench
=====================================

Name: param_counter_bank

Overview:
- Bank of CHANNELS independent WIDTH-bit up/down counters sharing one clock and reset.
- Each channel has per-channel enable, direction, synchronous clear, parallel load and a programmable limit.
- Each channel flags terminal count and sticky overflow.
- Next-generation general counter primitive for the simulator's Verilog test designs; replaces the fixed 4-bit free-running counters.

Parameters:
WIDTH, 4, counter bit width per channel (>=1)
CHANNELS, 3, number of independent counter channels (>=1)
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
clear  input  CHANNELS  per-channel synchronous clear
en  input  CHANNELS  per-channel count enable
dir  input  CHANNELS  per-channel direction, 1 = up, 0 = down
load  input  CHANNELS  per-channel synchronous parallel load
load_val  input  CHANNELS*WIDTH  load values; channel i occupies bits [i*WIDTH +: WIDTH]
limit  input  CHANNELS*WIDTH  per-channel top value, packed the same way
cnt  output  CHANNELS*WIDTH  registered counter values, packed the same way
tc  output  CHANNELS  registered terminal-count pulse
ovf  output  CHANNELS  registered sticky boundary flag

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, on port reset.
- Reset (reset=0, asynchronous): all cnt=0, tc=0, ovf=0 immediately; held while low. Counting resumes on the first rising clk edge after release.
- Per-channel priority on each rising edge: clear > load > en. All channels are fully independent.
- clear=1: cnt=0, tc=0, ovf=0.
- load=1 (clear=0):
  - cnt = min(load_val, limit); tc=0; ovf unchanged.
  - Load overrides en/dir.
- en=1, dir=1 (up):
  - If cnt < limit: cnt+1, tc=0.
  - If cnt >= limit (boundary): wrap mode gives cnt=0; saturate mode gives cnt=limit. In both modes tc=1, ovf=1.
- en=1, dir=0 (down):
  - If cnt > 0: cnt-1, tc=0.
  - If cnt == 0 (boundary): wrap mode gives cnt=limit; saturate mode gives cnt=0. In both modes tc=1, ovf=1.
- en=0 (no clear/load): cnt holds, tc=0, ovf holds.
- Timing:
  - tc is high exactly for the one cycle following an edge at which a boundary event occurred.
  - In saturate mode tc re-asserts on every enabled edge while held at the boundary.
- Latency: all outputs are registered; one cycle from input to cnt/tc/ovf.
- limit=0: channel stays at 0; every enabled edge is a boundary event (tc=1).
- limit lowered below the current cnt: the next up-count is a boundary event (wrap to 0 or hold at limit). The next down-count decrements normally.
- Width rules:
  - All compares are unsigned WIDTH-bit.
  - No intermediate carry bits are exposed.
  - limit = 2^WIDTH-1 gives natural full-range rollover.
- Inputs are sampled only at clk edges. No combinational path from any input to any output.

Decomposition:
- Shared include header: DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=0, MODE_SAT=1.
- Sub-module counter_channel: one WIDTH-bit channel with scalar ports plus SATURATE parameter.
- param_counter_bank instantiates counter_channel in a generate loop over CHANNELS and slices the packed buses.

Test Plan:
- Reset: drive reset=0 mid-count with cnt=9 -> all cnt=0, tc=0, ovf=0 asynchronously; release, en=1, dir=1 -> cnt 0,1,2 on successive edges.
- Wrap up (WIDTH=4, SATURATE=0), limit=5, en=1, dir=1 from 0 -> cnt 1,2,3,4,5,0; tc=1 only in the cycle cnt=0; ovf=1 thereafter.
- Wrap down, limit=5, cnt=1, dir=0 -> cnt 0 then 5 with tc=1; then 4 with tc=0.
- Saturate (SATURATE=1), limit=15, up from 13 -> cnt 14,15,15,15; tc=1 on each of the two hold cycles; down from 1 -> 0,0 with tc=1 on the second.
- Priority/clamp: load_val=12, limit=7 -> cnt=7; clear=1 with load=1 and en=1 on the same edge -> cnt=0, ovf=0; load=1 with en=1 -> cnt=load_val.
- Independence (CHANNELS=3): ch0 counts up, ch1 counts down, ch2 disabled -> ch2 holds 0; ch0/ch1 tc assert on their own edges only; limit lowered to 2 while ch0=6 -> next up edge gives cnt=0, tc=1.

Source files
------------

// File: rtl/param_counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// param_counter_bank_pkg
// Shared constants and helpers for the parameterised counter bank.
//   DIR_UP / DIR_DOWN    : encoding of the per-channel dir input
//   MODE_WRAP / MODE_SAT : values of the SATURATE parameter
//   chan_action_e        : what a channel does on a given clock edge
//   decode_action()      : resolves clear > load > en priority
// -----------------------------------------------------------------------------
package param_counter_bank_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_CLEAR = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_COUNT = 2'd3
    } chan_action_e;

    function automatic chan_action_e decode_action(input logic clear,
                                                   input logic load,
                                                   input logic en);
        chan_action_e act;
        if (clear)      act = ACT_CLEAR;
        else if (load)  act = ACT_LOAD;
        else if (en)    act = ACT_COUNT;
        else            act = ACT_HOLD;
        return act;
    endfunction

endpackage

// File: rtl/param_counter_bank_counter_channel.sv
// -----------------------------------------------------------------------------
// counter_channel
// One WIDTH-bit up/down counter with synchronous clear, clamped parallel load,
// programmable top value, terminal-count pulse and sticky boundary flag.
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_clear     synchronous clear (highest priority)
//   i_load      synchronous load of min(i_load_val, i_limit)
//   i_en        count enable
//   i_dir       1 = up, 0 = down
//   i_load_val  load value
//   i_limit     top value of the counting range
//   o_cnt       registered count
//   o_tc        one-cycle pulse after a boundary event
//   o_ovf       sticky boundary flag, cleared by reset or i_clear
// -----------------------------------------------------------------------------
module counter_channel
    import param_counter_bank_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_ovf
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;

    chan_action_e     w_action;
    logic             w_at_top;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_action       = decode_action(i_clear, i_load, i_en);
    // ">=" rather than "==" so a limit lowered below the count still
    // produces a boundary event on the next up-count.
    assign w_at_top       = (r_cnt >= i_limit);
    assign w_at_zero      = (r_cnt == '0);
    assign w_load_clamped = (i_load_val > i_limit) ? i_limit : i_load_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (w_action)
                ACT_CLEAR: begin
                    r_cnt <= '0;
                    r_tc  <= 1'b0;
                    r_ovf <= 1'b0;
                end
                ACT_LOAD: begin
                    r_cnt <= w_load_clamped;
                    r_tc  <= 1'b0;
                end
                ACT_COUNT: begin
                    case (i_dir)
                        DIR_UP: begin
                            if (w_at_top) begin
                                r_cnt <= (SATURATE == MODE_SAT) ? i_limit : '0;
                                r_tc  <= 1'b1;
                                r_ovf <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                                r_tc  <= 1'b0;
                            end
                        end
                        DIR_DOWN: begin
                            if (w_at_zero) begin
                                r_cnt <= (SATURATE == MODE_SAT) ? '0 : i_limit;
                                r_tc  <= 1'b1;
                                r_ovf <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                                r_tc  <= 1'b0;
                            end
                        end
                    endcase
                end
                default: begin
                    r_tc <= 1'b0;
                end
            endcase
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = r_tc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/param_counter_bank.sv
// -----------------------------------------------------------------------------
// param_counter_bank
// Bank of CHANNELS independent WIDTH-bit up/down counters on one clock/reset.
// Channel i uses bit i of the per-channel controls and bits [i*WIDTH +: WIDTH]
// of the packed value buses.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   clear     per-channel synchronous clear
//   en        per-channel count enable
//   dir       per-channel direction, 1 = up
//   load      per-channel synchronous load
//   load_val  packed load values
//   limit     packed top values
//   cnt       packed registered counts
//   tc        registered terminal-count pulses
//   ovf       registered sticky boundary flags
// -----------------------------------------------------------------------------
module param_counter_bank
    import param_counter_bank_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 3,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        counter_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_clear    (clear[g]),
            .i_en       (en[g]),
            .i_dir      (dir[g]),
            .i_load     (load[g]),
            .i_load_val (load_val[g*WIDTH +: WIDTH]),
            .i_limit    (limit[g*WIDTH +: WIDTH]),
            .o_cnt      (cnt[g*WIDTH +: WIDTH]),
            .o_tc       (tc[g]),
            .o_ovf      (ovf[g])
        );
    end

endmodule

// File: tb/tb_param_counter_bank.sv
module tb_param_counter_bank;
    import param_counter_bank_pkg::*;

    localparam int W  = 4;
    localparam int CH = 3;

    logic            clk;
    logic            reset;
    logic [CH-1:0]   clear, en, dir, load;
    logic [CH*W-1:0] load_val, limit;
    logic [CH*W-1:0] cnt_w, cnt_s;
    logic [CH-1:0]   tc_w, tc_s, ovf_w, ovf_s;

    param_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(MODE_WRAP)) u_dut_wrap (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .limit(limit), .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w));

    param_counter_bank #(.WIDTH(W), .CHANNELS(CH), .SATURATE(MODE_SAT)) u_dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .dir(dir), .load(load),
        .load_val(load_val), .limit(limit), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CH*W-1:0] cnt_w, cnt_s;
        logic [CH-1:0]   tc_w, tc_s, ovf_w, ovf_s;
    } exp_t;

    exp_t sb_q[$];

    // Reference state: index 0 = wrap instance, 1 = saturate instance
    logic [W-1:0] m_cnt [2][CH];
    logic         m_ovf [2][CH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_ch(input int sat, input logic [W-1:0] c, input logic o,
                                     input logic clr, ld, e, d,
                                     input logic [W-1:0] lv, lim,
                                     output logic [W-1:0] cn, output logic tn, output logic on);
        int ci, li;
        ci = int'(c);
        li = int'(lim);
        cn = c; tn = 1'b0; on = o;
        if (clr) begin
            cn = '0; on = 1'b0;
        end else if (ld) begin
            cn = (int'(lv) < li) ? lv : lim;
        end else if (e) begin
            if (d) begin
                if (ci < li) cn = W'(ci + 1);
                else begin
                    cn = sat ? lim : '0; tn = 1'b1; on = 1'b1;
                end
            end else begin
                if (ci > 0) cn = W'(ci - 1);
                else begin
                    cn = sat ? '0 : lim; tn = 1'b1; on = 1'b1;
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < CH; i++) begin
                m_cnt[m][i] = '0;
                m_ovf[m][i] = 1'b0;
            end
    endtask

    // Predict one edge, push the prediction, clock, then pop and compare.
    task automatic step(input string tag);
        exp_t e;
        logic [W-1:0] cn;
        logic tn, on;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < CH; i++) begin
                model_ch(m, m_cnt[m][i], m_ovf[m][i], clear[i], load[i], en[i], dir[i],
                         load_val[i*W +: W], limit[i*W +: W], cn, tn, on);
                m_cnt[m][i] = cn;
                m_ovf[m][i] = on;
                if (m == 0) begin
                    e.cnt_w[i*W +: W] = cn; e.tc_w[i] = tn; e.ovf_w[i] = on;
                end else begin
                    e.cnt_s[i*W +: W] = cn; e.tc_s[i] = tn; e.ovf_s[i] = on;
                end
            end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "/cnt_w"}, 32'(cnt_w), 32'(e.cnt_w));
        chk({tag, "/tc_w"},  32'(tc_w),  32'(e.tc_w));
        chk({tag, "/ovf_w"}, 32'(ovf_w), 32'(e.ovf_w));
        chk({tag, "/cnt_s"}, 32'(cnt_s), 32'(e.cnt_s));
        chk({tag, "/tc_s"},  32'(tc_s),  32'(e.tc_s));
        chk({tag, "/ovf_s"}, 32'(ovf_s), 32'(e.ovf_s));
    endtask

    task automatic set_ch(input int ch, input logic c, ld, e, d,
                          input logic [W-1:0] lv, lim);
        clear[ch] = c; load[ch] = ld; en[ch] = e; dir[ch] = d;
        load_val[ch*W +: W] = lv;
        limit[ch*W +: W]    = lim;
    endtask

    task automatic idle_all();
        clear = '0; load = '0; en = '0; dir = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_all();
        load_val = '0;
        limit = {CH{4'd15}};
        model_reset();
        #3;
        chk("rst/cnt_w", 32'(cnt_w), 32'd0);
        chk("rst/tc_w",  32'(tc_w),  32'd0);
        chk("rst/ovf_s", 32'(ovf_s), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reach 9 on ch0, then reset asynchronously between edges
        set_ch(0, 0, 1, 0, DIR_UP, 4'd9, 4'd15);
        step("ld9");
        set_ch(0, 0, 0, 1, DIR_UP, 4'd0, 4'd15);
        step("cnt10");
        #2;
        reset = 1'b0;
        #1;
        chk("arst/cnt_w", 32'(cnt_w), 32'd0);
        chk("arst/cnt_s", 32'(cnt_s), 32'd0);
        chk("arst/tc_w",  32'(tc_w),  32'd0);
        chk("arst/ovf_w", 32'(ovf_w), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step("post_rst1");
        chk("post_rst1/ch0", 32'(cnt_w[3:0]), 32'd1);
        step("post_rst2");
        chk("post_rst2/ch0", 32'(cnt_w[3:0]), 32'd2);

        // Wrap up with limit 5
        set_ch(0, 1, 0, 0, DIR_UP, 4'd0, 4'd5);
        step("clr");
        set_ch(0, 0, 0, 1, DIR_UP, 4'd0, 4'd5);
        for (int k = 0; k < 6; k++) step("wrap_up");
        chk("wrap_up/end", 32'(cnt_w[3:0]), 32'd0);
        chk("wrap_up/tc",  32'(tc_w[0]),    32'd1);
        step("wrap_up_after");
        chk("wrap_up/tc_low", 32'(tc_w[0]), 32'd0);
        chk("wrap_up/ovf",    32'(ovf_w[0]), 32'd1);

        // Wrap down from 1 with limit 5
        set_ch(0, 0, 1, 0, DIR_DOWN, 4'd1, 4'd5);
        step("ld1");
        set_ch(0, 0, 0, 1, DIR_DOWN, 4'd0, 4'd5);
        step("dn0");
        step("dn_wrap");
        chk("dn_wrap/cnt", 32'(cnt_w[3:0]), 32'd5);
        chk("dn_wrap/tc",  32'(tc_w[0]),    32'd1);
        step("dn4");

        // Saturate at top and bottom, full-range limit
        set_ch(0, 0, 1, 0, DIR_UP, 4'd13, 4'd15);
        step("ld13");
        set_ch(0, 0, 0, 1, DIR_UP, 4'd0, 4'd15);
        for (int k = 0; k < 4; k++) step("sat_up");
        chk("sat_up/cnt", 32'(cnt_s[3:0]), 32'd15);
        chk("sat_up/tc",  32'(tc_s[0]),    32'd1);
        set_ch(0, 0, 1, 0, DIR_DOWN, 4'd1, 4'd15);
        step("ld1s");
        set_ch(0, 0, 0, 1, DIR_DOWN, 4'd0, 4'd15);
        step("sat_dn0");
        step("sat_dn_hold");
        chk("sat_dn/tc", 32'(tc_s[0]), 32'd1);

        // Priority and load clamp
        set_ch(0, 0, 1, 0, DIR_UP, 4'd12, 4'd7);
        step("clamp");
        chk("clamp/cnt", 32'(cnt_w[3:0]), 32'd7);
        set_ch(0, 1, 1, 1, DIR_UP, 4'd3, 4'd7);
        step("clr_prio");
        set_ch(0, 0, 1, 1, DIR_UP, 4'd3, 4'd7);
        step("ld_prio");
        chk("ld_prio/cnt", 32'(cnt_w[3:0]), 32'd3);

        // Independence: ch0 up, ch1 down, ch2 disabled
        idle_all();
        clear = '1;
        step("clr_all");
        set_ch(0, 0, 0, 1, DIR_UP,   4'd0, 4'd7);
        set_ch(1, 0, 1, 0, DIR_DOWN, 4'd3, 4'd3);
        set_ch(2, 0, 0, 0, DIR_UP,   4'd0, 4'd4);
        step("ind_ld");
        set_ch(1, 0, 0, 1, DIR_DOWN, 4'd0, 4'd3);
        for (int k = 0; k < 5; k++) step("ind");
        chk("ind/ch2_hold", 32'(cnt_w[11:8]), 32'd0);
        chk("ind/ch0",      32'(cnt_w[3:0]),  32'd6);
        set_ch(0, 0, 0, 1, DIR_UP, 4'd0, 4'd2);
        step("lim_drop");
        chk("lim_drop/cnt_w", 32'(cnt_w[3:0]), 32'd0);
        chk("lim_drop/cnt_s", 32'(cnt_s[3:0]), 32'd2);
        chk("lim_drop/tc",    32'(tc_w[0]),    32'd1);

        // limit = 0
        set_ch(2, 0, 0, 1, DIR_UP, 4'd0, 4'd0);
        step("lim0");
        chk("lim0/tc", 32'(tc_w[2]), 32'd1);

        // Random mix
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < CH; i++)
                set_ch(i, ($urandom_range(15) == 0), ($urandom_range(7) == 0),
                       1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
